mac_array_ctrl: RTL and testbench

Sequencer for a `row` x `col` systolic array of `mac_tile` instances. It runs one complete pass on each start pulse:
- kernel load;
- activation execute;
- pipeline drain;
- done.

For each pass it generates the per-row 2-bit west instruction bus with diagonal skew, the read address stream for the weight/activation SRAM feeding the west edge, and per-column psum-valid strobes for the south-edge output FIFO.

---
 rtl/mac_array_ctrl.sv | 157 +++++++++++++++
 tb/tb_mac_array_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mac_array_ctrl.sv
// Pass sequencer for a row x col systolic MAC array: kernel load, execute, drain, done.
// Optional busy-cycle counter (perf_cycles) when MAC_CTRL_PERF_CNT_EN is defined.
module mac_array_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_bw-1:0]    num_act,
  output logic                 busy,
  output logic                 done,
  output logic [2*row-1:0]     inst_w,
  output logic                 mem_rd_en,
  output logic [addr_bw-1:0]   mem_addr,
  output logic [col-1:0]       psum_valid
`ifdef MAC_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);

  localparam int DRAIN_LEN = row + col;
  localparam int CNT_W     = (len_bw > $clog2(DRAIN_LEN)) ? len_bw : $clog2(DRAIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [len_bw-1:0]    num_q, num_d;
  logic                 accept;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [addr_bw-1:0]   addr_q, addr_d;
  logic [1:0]           inst_base_d;
  logic [2*row-1:0]     inst_w_q, inst_w_d;
  logic [col-1:0]       psum_valid_q, psum_valid_d;

  assign accept = (state_q == S_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  // Next-state: cnt_q holds remaining cycles minus one in the current phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        cnt_d   = CNT_W'(col - 1);
        num_d   = num_act;
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          if (num_q == '0) begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(DRAIN_LEN - 1);
          end else begin
            state_d = S_EXEC;
            cnt_d   = CNT_W'(num_q) - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(DRAIN_LEN - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with state_q
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_en_d     = (state_d == S_LOAD) || (state_d == S_EXEC);
    inst_base_d = (state_d == S_LOAD) ? 2'b01 :
                  (state_d == S_EXEC) ? 2'b10 : 2'b00;
    addr_d      = addr_q;
    if (accept)                addr_d = '0;
    else if (rd_en_q && rd_en_d) addr_d = addr_q + addr_bw'(1);
    // Row 0 is the base instruction; each row below sees the row above one cycle later
    inst_w_d     = {inst_w_q[2*row-3:0], inst_base_d};
    // Bottom row's execute bit is already row-1 cycles late; column c adds c more
    psum_valid_d = {psum_valid_q[col-2:0], inst_w_q[2*row-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      inst_w_q     <= '0;
      psum_valid_q <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      inst_w_q     <= inst_w_d;
      psum_valid_q <= psum_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign inst_w     = inst_w_q;
  assign psum_valid = psum_valid_q;

`ifdef MAC_CTRL_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                          perf_d = '0;
    else if (busy_q && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: table of passes checked cycle-by-cycle against a
// timing model, plus hand sequences for back-to-back start and mid-pass reset.
module tb_mac_array_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LBW = 8;
  localparam int ABW = 4;   // narrow address so long passes wrap

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LBW-1:0]   num_act;
  logic             busy, done, mem_rd_en;
  logic [2*ROW-1:0] inst_w;
  logic [ABW-1:0]   mem_addr;
  logic [COL-1:0]   psum_valid;
`ifdef MAC_CTRL_PERF_CNT_EN
  logic [15:0]      perf_cycles;
`endif

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_act(num_act),
    .busy(busy), .done(done), .inst_w(inst_w), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .psum_valid(psum_valid)
`ifdef MAC_CTRL_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got %0h want %0h", nm, k, act, exp);
    end
  endtask

  // Base instruction j cycles into a pass (j=1 is the first cycle after acceptance)
  function automatic logic [1:0] base_at(input int j, input int n);
    if (j >= 1 && j <= COL)          return 2'b01;
    if (j > COL && j <= COL + n)     return 2'b10;
    return 2'b00;
  endfunction

  // Sample cycles k=1..len+extra after an accepting edge; at k=1 drop start if asked
  // and change num_act to show the latched count is used.
  task automatic check_pass(input int n, input int len, input int perf_exp,
                            input bit drop_start, input logic [LBW-1:0] next_num,
                            input int extra);
    logic [2*ROW-1:0] e_inst;
    logic [COL-1:0]   e_pv;
    for (int k = 1; k <= len + extra; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (drop_start) start = 1'b0;
        num_act = next_num;
      end
      for (int r = 0; r < ROW; r++) e_inst[2*r +: 2] = base_at(k - r, n);
      for (int c = 0; c < COL; c++) e_pv[c] = (base_at(k - ROW - c, n) == 2'b10);
      chk("busy",   k, 32'(busy),      32'(k <= len));
      chk("done",   k, 32'(done),      32'(k == len));
      chk("rd_en",  k, 32'(mem_rd_en), 32'(k <= COL + n));
      if (k <= COL + n) chk("addr", k, 32'(mem_addr), 32'((k - 1) % (1 << ABW)));
      chk("inst_w", k, 32'(inst_w),    32'(e_inst));
      chk("psum_v", k, 32'(psum_valid),32'(e_pv));
`ifdef MAC_CTRL_PERF_CNT_EN
      if (k == len + 1) chk("perf", k, 32'(perf_cycles), 32'(perf_exp));
`else
      if (perf_exp < 0) $display("bad perf expectation");
`endif
    end
  endtask

  task automatic chk_all_zero(input string nm, input int k);
    chk({nm, "_busy"},  k, 32'(busy),       32'd0);
    chk({nm, "_done"},  k, 32'(done),       32'd0);
    chk({nm, "_rd"},    k, 32'(mem_rd_en),  32'd0);
    chk({nm, "_addr"},  k, 32'(mem_addr),   32'd0);
    chk({nm, "_inst"},  k, 32'(inst_w),     32'd0);
    chk({nm, "_pv"},    k, 32'(psum_valid), 32'd0);
  endtask

  typedef struct {
    int n;      // num_act
    int len;    // accept edge to done, hand-computed: 8+n+16+1
    int perf;   // busy cycles of the pass
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{n: 4,  len: 29, perf: 29};
    vecs[1] = '{n: 0,  len: 25, perf: 25};
    vecs[2] = '{n: 1,  len: 26, perf: 26};
    vecs[3] = '{n: 3,  len: 28, perf: 28};
    vecs[4] = '{n: 12, len: 37, perf: 37};   // addresses 0..19 wrap at 16

    reset = 1'b1; start = 1'b0; num_act = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_all_zero("idle", k);
    end

    for (int i = 0; i < 5; i++) begin
      start = 1'b1; num_act = LBW'(vecs[i].n);
      check_pass(vecs[i].n, vecs[i].len, vecs[i].perf, 1'b1, 8'hA5, 2);
    end

    // start held through a pass (ignored while busy and in DONE), accepted in the
    // following IDLE cycle; second pass latches num_act=1 set mid-first-pass
    start = 1'b1; num_act = 8'd4;
    check_pass(4, 29, 29, 1'b0, 8'd1, 1);
    check_pass(1, 26, 26, 1'b1, 8'hFF, 2);

    // reset during EXEC clears everything on the same edge
    start = 1'b1; num_act = 8'd4;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst", 11);
`ifdef MAC_CTRL_PERF_CNT_EN
    chk("rst_perf", 11, 32'(perf_cycles), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst", 12);
    start = 1'b1; num_act = 8'd2;
    check_pass(2, 27, 27, 1'b1, 8'd0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
